// File: rtl/cen_accumulator.sv
// Frame accumulator for the centering path: sums N_SAMPLES four-channel samples
// and presents the registered frame sums with a one-cycle sum_valid strobe.
module cen_accumulator #(
    parameter int DATA_W    = 32,
    parameter int SUM_W     = 40,
    parameter int N_SAMPLES = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    input  logic [DATA_W-1:0] x4,
    output logic              busy,
    output logic              sum_valid,
    output logic [SUM_W-1:0]  sum1,
    output logic [SUM_W-1:0]  sum2,
    output logic [SUM_W-1:0]  sum3,
    output logic [SUM_W-1:0]  sum4,
    output logic              dbg_state
);

    localparam int CNT_W = $clog2(N_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on registered state, never on in_valid.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0][SUM_W-1:0]   acc_q, acc_d;
    logic [3:0][SUM_W-1:0]   sum_q, sum_d;
    logic                    sum_valid_q, sum_valid_d;
    logic [3:0][SUM_W-1:0]   x_ext;
    logic                    accept;
    logic                    last_accept;

    assign x_ext[0]    = SUM_W'(x1);
    assign x_ext[1]    = SUM_W'(x2);
    assign x_ext[2]    = SUM_W'(x3);
    assign x_ext[3]    = SUM_W'(x4);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (last_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        busy      = (state_q == ACCUM);
        dbg_state = state_q;
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        if (state_q == IDLE && start) begin
            acc_d = '0;
            cnt_d = '0;
        end
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                acc_d[i] = acc_q[i] + x_ext[i];
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (last_accept) begin
                // The sum outputs take the completed totals directly, so they
                // are valid in the same cycle the strobe is high.
                for (int i = 0; i < 4; i++) begin
                    sum_d[i] = acc_q[i] + x_ext[i];
                end
                sum_valid_d = 1'b1;
                cnt_d       = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum_valid = sum_valid_q;
    assign sum1      = sum_q[0];
    assign sum2      = sum_q[1];
    assign sum3      = sum_q[2];
    assign sum4      = sum_q[3];

endmodule

// File: doc/cen_accumulator.md
# cen_accumulator

Upstream stage of the whitening centering path. Accumulates a frame of N_SAMPLES four-channel unsigned samples into four wide running sums. On frame completion it presents the sums, with a one-cycle strobe, to the divide-by-128 unit that forms the per-channel means. One frame per `start`; sums hold stable until the next frame completes.

## Interface
- `DATA_W`, 32, width of each unsigned input sample
- `SUM_W`, 40, width of each accumulator and sum output; must satisfy SUM_W ≥ DATA_W + clog2(N_SAMPLES)
- `N_SAMPLES`, 128, samples per frame; power of two, ≥ 2; must match the downstream shift (128 ↔ >>7)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin new frame; honoured only in IDLE
- `in_valid`  in  1  x1..x4 carry a valid sample
- `in_ready`  out  1  block accepts a sample this cycle
- `x1`..`x4`  in  DATA_W each  unsigned channel samples
- `busy`  out  1  high while in ACCUM
- `sum_valid`  out  1  one-cycle strobe: sum1..sum4 newly updated; drives the divider `En`
- `sum1`..`sum4`  out  SUM_W each  unsigned frame sums, registered

## Operation
- States: IDLE, ACCUM.
- IDLE: `in_ready`=0. On `start`=1: clear acc1..acc4 and sample counter to 0; next state ACCUM.
- ACCUM: `in_ready`=1, `busy`=1. A sample is accepted when `in_valid`&&`in_ready`; each acc_i ← acc_i + x_i (zero-extended to SUM_W), counter += 1. No accept → all state holds (stalls of any length allowed).
- Final sample (counter == N_SAMPLES-1 and accepted): sum_i ← acc_i + x_i; `sum_valid` ← 1 for the next cycle only; next state IDLE; counter returns to 0.
- `start` while in ACCUM is ignored; it does not restart or extend the frame.
- `start` in the cycle `sum_valid` is high (block is already in IDLE) is honoured: the new frame begins and `sum1`..`sum4` stay unchanged until that frame completes.
- Arithmetic: unsigned, modulo 2^SUM_W. The parameter rule guarantees no wrap at the defaults. Worst case is 128×(2^32−1) = 0x7F_FFFF_FF80.
- `sum1`..`sum4` change only on a final-sample accept. Downstream may sample them on `sum_valid` or any later cycle.

## Timing
- Reset (asynchronous assert, synchronous deassert to `clk`): state IDLE, counter 0, acc1..acc4 = 0, `sum1`..`sum4` = 0, `sum_valid` = 0, `in_ready` = 0, `busy` = 0.
- Reset mid-frame: partial sums are discarded and no `sum_valid` is produced. After release the block waits in IDLE for `start`.
- `start` at edge t → `in_ready` high from cycle t+1.
- Last accept at edge t → `sum_valid` high and `sum_i` valid during cycle t+1; `busy`/`in_ready` low from t+1.
- Minimum frame length: 1 + N_SAMPLES cycles (start plus back-to-back accepts). Divider result follows one cycle after `sum_valid`.
- `in_ready` is a registered-state decode and does not depend combinationally on `in_valid`.

## Test plan
- Ramp frame: start, then 128 back-to-back samples x1=k, x2=1, x3=1000, x4=2k (k=0..127). Required: `sum_valid` pulses once, 1 cycle after the last accept, with sums 8128, 128, 128000, 16256; `busy` falls the same cycle.
- Max values: all inputs 0xFFFF_FFFF for 128 samples → every sum = 0x7F_FFFF_FF80, no wrap.
- Stalls: same ramp frame with `in_valid` low on random cycles (≥30% of cycles) → identical sums. `sum_valid` only after the 128th accept; held inputs during stalls are not accumulated.
- Ignored start: pulse `start` at sample 50 of a constant-5 frame → frame still ends after 128 accepts with sums 640, and exactly one `sum_valid` pulse.
- Back-to-back frames: `start` during the `sum_valid` cycle, second frame all 2s. Required: first sums (all 128 with inputs 1) hold until the second `sum_valid`, then become 256.
- Mid-frame reset: assert `rst_n`=0 after 60 samples → all outputs 0 immediately (asynchronously). A subsequent full frame of 3s yields 384, with no contamination from the aborted frame.
